apb_rr_arbiter: RTL and testbench

- Shares one APB master port (toward apb_async_bridge, clk_a side) between two APB requesters, e.g. apb_master plus a debug/DMA master.
- Round-robin grant, held for a whole APB transfer.
- Registered request capture and registered response return.
- Per-requester completed-transfer counters for debug/performance visibility.

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 20 ++
 rtl/apb_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB round-robin arbiter.
package apb_arb_pkg;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on contention the requester that
// did not win last time is chosen.
module rr_pick2
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output logic               valid,
    output req_idx_t           winner
);

    always_comb begin
        valid  = |req;
        winner = req_idx_t'(req[1]);
        if (&req) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one downstream APB port between two requesters with round-robin
// grant held for a full transfer, plus per-requester transfer counters.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s0_psel,
    input  logic              s0_penable,
    input  logic              s0_pwrite,
    input  logic [ADDR_W-1:0] s0_paddr,
    input  logic [DATA_W-1:0] s0_pwdata,
    output logic              s0_pready,
    output logic [DATA_W-1:0] s0_prdata,

    input  logic              s1_psel,
    input  logic              s1_penable,
    input  logic              s1_pwrite,
    input  logic [ADDR_W-1:0] s1_paddr,
    input  logic [DATA_W-1:0] s1_pwdata,
    output logic              s1_pready,
    output logic [DATA_W-1:0] s1_prdata,

    output logic              m_psel,
    output logic              m_penable,
    output logic              m_pwrite,
    output logic [ADDR_W-1:0] m_paddr,
    output logic [DATA_W-1:0] m_pwdata,
    input  logic              m_pready,
    input  logic [DATA_W-1:0] m_prdata,

    input  logic              clr_cnt,
    output logic              grant,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    arb_state_t           state;
    req_idx_t             grant_q;
    logic                 pick_valid;
    req_idx_t             pick_winner;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic                 lat_write;
    logic                 m_psel_q;
    logic                 m_penable_q;
    logic [NUM_REQ-1:0]   pready_q;
    logic [DATA_W-1:0]    prdata0_q;
    logic [DATA_W-1:0]    prdata1_q;
    logic [CNT_W-1:0]     cnt0_q;
    logic [CNT_W-1:0]     cnt1_q;

    // Requests are psel alone; penable is accepted but carries no meaning here.
    logic penable_unused;
    assign penable_unused = s0_penable ^ s1_penable;

    rr_pick2 u_pick (
        .req    ({s1_psel, s0_psel}),
        .last   (grant_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            grant_q     <= '1;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            pready_q    <= '0;
            prdata0_q   <= '0;
            prdata1_q   <= '0;
        end else begin
            pready_q <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        lat_addr  <= pick_winner[0] ? s1_paddr  : s0_paddr;
                        lat_wdata <= pick_winner[0] ? s1_pwdata : s0_pwdata;
                        lat_write <= pick_winner[0] ? s1_pwrite : s0_pwrite;
                        grant_q   <= pick_winner;
                        m_psel_q  <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_penable_q <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Read data goes straight into the granted requester's
                    // holding register so it is valid alongside the pready pulse.
                    if (m_pready) begin
                        m_psel_q          <= 1'b0;
                        m_penable_q       <= 1'b0;
                        pready_q[grant_q] <= 1'b1;
                        if (grant_q[0]) begin
                            prdata1_q <= m_prdata;
                        end else begin
                            prdata0_q <= m_prdata;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (clr_cnt) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state == ST_RESP) begin
            if (grant_q[0]) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end else begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
        end
    end

    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_paddr   = lat_addr;
    assign m_pwdata  = lat_wdata;
    assign m_pwrite  = lat_write;

    assign s0_pready = pready_q[0];
    assign s1_pready = pready_q[1];
    assign s0_prdata = prdata0_q;
    assign s1_prdata = prdata1_q;

    assign grant = grant_q[0];
    assign busy  = (state != ST_IDLE);
    assign cnt0  = cnt0_q;
    assign cnt1  = cnt1_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter with a behavioural
// downstream slave (programmable wait states) and a transfer log.
module tb_apb_rr_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              s0_psel, s0_penable, s0_pwrite;
    logic [ADDR_W-1:0] s0_paddr;
    logic [DATA_W-1:0] s0_pwdata;
    logic              s0_pready;
    logic [DATA_W-1:0] s0_prdata;
    logic              s1_psel, s1_penable, s1_pwrite;
    logic [ADDR_W-1:0] s1_paddr;
    logic [DATA_W-1:0] s1_pwdata;
    logic              s1_pready;
    logic [DATA_W-1:0] s1_prdata;
    logic              m_psel, m_penable, m_pwrite;
    logic [ADDR_W-1:0] m_paddr;
    logic [DATA_W-1:0] m_pwdata;
    logic              m_pready;
    logic [DATA_W-1:0] m_prdata;
    logic              clr_cnt;
    logic              grant;
    logic              busy;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    apb_rr_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s0_psel    (s0_psel),
        .s0_penable (s0_penable),
        .s0_pwrite  (s0_pwrite),
        .s0_paddr   (s0_paddr),
        .s0_pwdata  (s0_pwdata),
        .s0_pready  (s0_pready),
        .s0_prdata  (s0_prdata),
        .s1_psel    (s1_psel),
        .s1_penable (s1_penable),
        .s1_pwrite  (s1_pwrite),
        .s1_paddr   (s1_paddr),
        .s1_pwdata  (s1_pwdata),
        .s1_pready  (s1_pready),
        .s1_prdata  (s1_prdata),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_pready   (m_pready),
        .m_prdata   (m_prdata),
        .clr_cnt    (clr_cnt),
        .grant      (grant),
        .busy       (busy),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    // Downstream slave: ready after 'waits' ACCESS cycles, logs each completed transfer.
    int                waits = 0;
    int                wcnt  = 0;
    logic [DATA_W-1:0] slave_rdata = '0;
    logic [5:0]        log_n = '0;
    logic [ADDR_W-1:0] log_addr  [64];
    logic [DATA_W-1:0] log_wdata [64];
    logic              log_write [64];

    assign m_pready = m_psel && m_penable && (wcnt == waits);
    assign m_prdata = slave_rdata;

    always @(posedge clk) begin
        if (m_psel && m_penable && !m_pready) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (m_psel && m_penable && m_pready) begin
            log_addr[log_n]  <= m_paddr;
            log_wdata[log_n] <= m_pwdata;
            log_write[log_n] <= m_pwrite;
            log_n            <= log_n + 6'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until requester idx sees pready; also report whether the other one ever did.
    task automatic wait_resp(input int idx, input int budget, output int cycles, output logic other_seen);
        logic done;
        done       = 1'b0;
        cycles     = 0;
        other_seen = 1'b0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
            if (idx == 1 ? s0_pready : s1_pready) other_seen = 1'b1;
            if (idx == 1 ? s1_pready : s0_pready) done = 1'b1;
        end
        if (!done) check("resp_timeout", idx == 1 ? s1_pready : s0_pready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic       other;
        logic [5:0] base;
        logic       done;

        rst = 1'b0;
        clr_cnt = 1'b0;
        s0_psel = 1'b0; s0_penable = 1'b0; s0_pwrite = 1'b0; s0_paddr = '0; s0_pwdata = '0;
        s1_psel = 1'b0; s1_penable = 1'b0; s1_pwrite = 1'b0; s1_paddr = '0; s1_pwdata = '0;
        repeat (2) @(posedge clk);
        #1;

        check("rst_m_psel",    m_psel, 1'b0);
        check("rst_m_penable", m_penable, 1'b0);
        check("rst_m_paddr",   m_paddr, '0);
        check("rst_s0_pready", s0_pready, 1'b0);
        check("rst_s0_prdata", s0_prdata, '0);
        check("rst_grant",     grant, 1'b1);
        check("rst_busy",      busy, 1'b0);
        check("rst_cnt0",      cnt0, '0);

        @(negedge clk) rst = 1'b1;
        tick();

        // Single zero-wait read from requester 0.
        s0_psel = 1'b1; s0_paddr = 32'h10; s0_pwrite = 1'b0;
        slave_rdata = 32'hCAFE_0001;
        waits = 0;
        tick();
        check("t1_setup_psel",    m_psel, 1'b1);
        check("t1_setup_penable", m_penable, 1'b0);
        check("t1_setup_paddr",   m_paddr, 32'h10);
        check("t1_setup_grant",   grant, 1'b0);
        check("t1_setup_busy",    busy, 1'b1);
        s0_penable = 1'b1;
        tick();
        check("t1_access_penable", m_penable, 1'b1);
        check("t1_access_pready",  s0_pready, 1'b0);
        tick();
        check("t1_resp_pready", s0_pready, 1'b1);
        check("t1_resp_prdata", s0_prdata, 32'hCAFE_0001);
        check("t1_resp_m_psel", m_psel, 1'b0);
        s0_psel = 1'b0; s0_penable = 1'b0;
        tick();
        check("t1_idle_pready", s0_pready, 1'b0);
        check("t1_prdata_hold", s0_prdata, 32'hCAFE_0001);
        check("t1_cnt0",        cnt0, 4'd1);
        check("t1_busy",        busy, 1'b0);

        // Simultaneous writes right after reset: requester 0 first.
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();
        base = log_n;
        s0_psel = 1'b1; s0_penable = 1'b1; s0_pwrite = 1'b1; s0_paddr = 32'h20; s0_pwdata = 32'h11;
        s1_psel = 1'b1; s1_penable = 1'b1; s1_pwrite = 1'b1; s1_paddr = 32'h24; s1_pwdata = 32'h22;
        wait_resp(0, 20, cyc, other);
        check("t2_s0_latency", cyc, 3);
        check("t2_s1_waits",   other, 1'b0);
        s0_psel = 1'b0; s0_penable = 1'b0;
        wait_resp(1, 20, cyc, other);
        check("t2_s1_latency", cyc, 4);
        s1_psel = 1'b0; s1_penable = 1'b0;
        check("t2_log0_addr",  log_addr[base], 32'h20);
        check("t2_log0_data",  log_wdata[base], 32'h11);
        check("t2_log0_write", log_write[base], 1'b1);
        check("t2_log1_addr",  log_addr[base + 6'd1], 32'h24);
        check("t2_log1_data",  log_wdata[base + 6'd1], 32'h22);
        tick();
        check("t2_cnt0", cnt0, 4'd1);
        check("t2_cnt1", cnt1, 4'd1);

        // Clear, then continuous contention: strict alternation.
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t3_clr_cnt0", cnt0, 4'd0);
        check("t3_clr_cnt1", cnt1, 4'd1 - 4'd1);
        s0_psel = 1'b1; s0_pwrite = 1'b0; s0_paddr = 32'h100;
        s1_psel = 1'b1; s1_pwrite = 1'b0; s1_paddr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 20) begin
                tick();
                cyc++;
                done = s0_pready | s1_pready;
            end
            if (!done) check("t3_timeout", s0_pready | s1_pready, 1'b1);
            check($sformatf("t3_winner_%0d", k), s1_pready, k[0]);
            check($sformatf("t3_grant_%0d", k),  grant, k[0]);
            if (k == 5) begin
                s0_psel = 1'b0;
                s1_psel = 1'b0;
            end
        end
        tick();
        check("t3_cnt0", cnt0, 4'd3);
        check("t3_cnt1", cnt1, 4'd3);

        // Read with three downstream wait states from requester 1.
        s1_psel = 1'b1; s1_penable = 1'b1; s1_pwrite = 1'b0; s1_paddr = 32'h30;
        slave_rdata = 32'hDEAD_BEEF;
        waits = 3;
        tick();
        check("t4_setup_psel",    m_psel, 1'b1);
        check("t4_setup_penable", m_penable, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t4_penable_%0d", i), m_penable, 1'b1);
            check($sformatf("t4_paddr_%0d", i),   m_paddr, 32'h30);
            check($sformatf("t4_pready_%0d", i),  s1_pready, 1'b0);
        end
        tick();
        check("t4_resp_pready", s1_pready, 1'b1);
        check("t4_resp_prdata", s1_prdata, 32'hDEAD_BEEF);
        s1_psel = 1'b0; s1_penable = 1'b0;
        tick();
        check("t4_pready_once", s1_pready, 1'b0);
        check("t4_prdata_hold", s1_prdata, 32'hDEAD_BEEF);
        check("t4_cnt1",        cnt1, 4'd4);

        // Asynchronous reset in the middle of ACCESS.
        s0_psel = 1'b1; s0_penable = 1'b1; s0_pwrite = 1'b0; s0_paddr = 32'h40;
        slave_rdata = 32'h1234;
        tick();
        tick();
        check("t5_in_access", m_penable, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_m_psel",    m_psel, 1'b0);
        check("t5_rst_m_penable", m_penable, 1'b0);
        check("t5_rst_busy",      busy, 1'b0);
        check("t5_rst_grant",     grant, 1'b1);
        check("t5_rst_cnt0",      cnt0, 4'd0);
        check("t5_rst_cnt1",      cnt1, 4'd0);
        check("t5_rst_s1_prdata", s1_prdata, 32'h0);
        s0_psel = 1'b0; s0_penable = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();
        waits = 0;
        s1_psel = 1'b1; s1_penable = 1'b1; s1_pwrite = 1'b1; s1_paddr = 32'h50; s1_pwdata = 32'h55;
        wait_resp(1, 10, cyc, other);
        check("t5_s1_latency", cyc, 3);
        s1_psel = 1'b0; s1_penable = 1'b0;
        tick();
        check("t5_cnt1", cnt1, 4'd1);
        check("t5_cnt0", cnt0, 4'd0);

        // Counter wrap (4-bit instance) and clear colliding with RESP.
        s0_psel = 1'b1; s0_penable = 1'b1; s0_pwrite = 1'b1; s0_paddr = 32'h60; s0_pwdata = 32'h66;
        for (int k = 0; k < 15; k++) begin
            wait_resp(0, 10, cyc, other);
        end
        s0_psel = 1'b0;
        tick();
        check("t6_cnt0_15", cnt0, 4'd15);
        s0_psel = 1'b1;
        wait_resp(0, 10, cyc, other);
        s0_psel = 1'b0;
        tick();
        check("t6_cnt0_wrap", cnt0, 4'd0);
        s0_psel = 1'b1;
        wait_resp(0, 10, cyc, other);
        check("t6_resp_seen", s0_pready, 1'b1);
        s0_psel = 1'b0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t6_clr_wins_cnt0", cnt0, 4'd0);
        check("t6_clr_wins_cnt1", cnt1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
